sensor_access_ctrl: RTL



---
 rtl/sensor_access_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sensor_access_ctrl.sv
// Sensor access controller: zero-wait local registers, remote sensor-bus accesses and a periodic channel poller.
// Remote accesses stall the host via slave_wait for at least 2 cycles; bus_req is held until bus_ack or timeout.
module sensor_access_ctrl #(
    parameter int NUM_CHANNELS = 4,
    parameter int POLL_PERIOD  = 1000,
    parameter int TIMEOUT      = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        renable,
    input  logic        wenable,
    input  logic [15:0] address,
    input  logic [15:0] command_data,
    output logic [31:0] sensor_data,
    output logic        slave_wait,
    output logic        bus_req,
    output logic        bus_write,
    output logic [3:0]  bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [15:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, HOST_BUS, POLL_BUS, HOST_DONE} state_t;

    localparam int              TW       = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [TW-1:0]   PER_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [1:0]      CH_LAST  = 2'(NUM_CHANNELS - 1);

    state_t        state_q;
    logic          poll_en_q, err_q, tout_q, pending_q, host_rd_q;
    logic          err_d, tout_d, pending_d;
    logic [1:0]    chan_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tcnt_q;
    logic [15:0]   cache_q [4];
    logic [31:0]   rdata_q;
    logic          bus_req_q, bus_write_q;
    logic [3:0]    bus_addr_q;
    logic [15:0]   bus_wdata_q;

    logic        strobe, remote, ctrl_wr, clr_err, expire, in_bus, tmo;
    logic        new_err, take_poll, busy;
    logic [31:0] local_rd;
    logic        unused_addr;

    assign unused_addr = ^address[15:5];

    assign strobe    = renable | wenable;
    assign remote    = strobe & address[4];
    assign ctrl_wr   = wenable & (address[4:0] == 5'h00);
    assign clr_err   = ctrl_wr & command_data[1];
    assign expire    = poll_en_q & (timer_q == PER_LAST);
    assign in_bus    = (state_q == HOST_BUS) | (state_q == POLL_BUS);
    assign tmo       = in_bus & ~bus_ack & (tcnt_q == TO_LAST);
    assign new_err   = in_bus & bus_ack & bus_err;
    assign take_poll = (state_q == IDLE) & ~remote & pending_q;
    assign busy      = (state_q != IDLE);

    // A fresh error in the same cycle as clear_err must survive the clear.
    always_comb begin
        err_d     = (err_q & ~clr_err) | new_err;
        tout_d    = (tout_q & ~clr_err) | tmo;
        timer_d   = '0;
        pending_d = 1'b0;
        if (poll_en_q) begin
            timer_d   = expire ? '0 : timer_q + TW'(1);
            pending_d = (pending_q & ~take_poll) | expire;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            poll_en_q <= 1'b0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
            pending_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            if (ctrl_wr) poll_en_q <= command_data[0];
            err_q     <= err_d;
            tout_q    <= tout_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            tcnt_q      <= '0;
            rdata_q     <= '0;
            host_rd_q   <= 1'b0;
            chan_q      <= '0;
            for (int i = 0; i < 4; i++) cache_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (remote) begin
                        state_q     <= HOST_BUS;
                        bus_req_q   <= 1'b1;
                        bus_write_q <= wenable;
                        bus_addr_q  <= address[3:0];
                        bus_wdata_q <= command_data;
                        host_rd_q   <= ~wenable;
                        tcnt_q      <= '0;
                    end else if (pending_q) begin
                        state_q     <= POLL_BUS;
                        bus_req_q   <= 1'b1;
                        bus_write_q <= 1'b0;
                        bus_addr_q  <= {2'b00, chan_q};
                        bus_wdata_q <= '0;
                        tcnt_q      <= '0;
                    end
                end
                HOST_BUS: begin
                    if (bus_ack | tmo) begin
                        state_q   <= HOST_DONE;
                        bus_req_q <= 1'b0;
                        rdata_q   <= (bus_ack & ~bus_err) ? {16'h0, bus_rdata} : 32'h0000_DEAD;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                POLL_BUS: begin
                    // A failed poll keeps the stale cache entry but still moves on.
                    if (bus_ack | tmo) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        if (bus_ack & ~bus_err) cache_q[chan_q] <= bus_rdata;
                        chan_q    <= (chan_q == CH_LAST) ? 2'd0 : chan_q + 2'd1;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                HOST_DONE: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        local_rd = '0;
        case (address[4:0])
            5'h00: local_rd = {31'h0, poll_en_q};
            5'h01: local_rd = {26'h0, chan_q, 1'b0, tout_q, err_q, busy};
            5'h04, 5'h05, 5'h06, 5'h07:
                if ({30'd0, address[1:0]} < 32'(NUM_CHANNELS))
                    local_rd = {16'h0, cache_q[address[1:0]]};
            default: local_rd = '0;
        endcase
    end

    // Outputs are gated by reset so an in-flight stall releases immediately.
    always_comb begin
        sensor_data = '0;
        if (HRESETn) begin
            if ((state_q == HOST_DONE) && host_rd_q) sensor_data = rdata_q;
            else if (renable && !address[4])         sensor_data = local_rd;
        end
    end

    assign slave_wait = HRESETn & ((state_q == HOST_BUS) |
                                   (remote & ((state_q == IDLE) | (state_q == POLL_BUS))));

    assign bus_req   = bus_req_q;
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
